// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers for the adder/subtractor/resize family.
package fixed_pkg;

    function automatic int unsigned fx_int_bits(input int unsigned width, input int unsigned point);
        return width - point;
    endfunction

    function automatic int unsigned fx_imax(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    function automatic longint fx_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint fx_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic bit fx_fmt_ok(input int unsigned width, input int unsigned point);
        return (width >= 2) && (point < width);
    endfunction

endpackage

// File: rtl/fixed_resize.sv
// Combinational binary-point move with round-half-up and saturation.
module fixed_resize
    import fixed_pkg::*;
#(
    parameter int unsigned InWidth  = 21,
    parameter int unsigned InPoint  = 12,
    parameter int unsigned OutWidth = 16,
    parameter int unsigned OutPoint = 13
) (
    input  logic signed [InWidth-1:0]  value,
    output logic signed [OutWidth-1:0] result,
    output logic                       overflow
);

    localparam int unsigned ShL = (OutPoint >= InPoint) ? OutPoint - InPoint : 0;
    localparam int unsigned ShR = (InPoint > OutPoint) ? InPoint - OutPoint : 0;
    // One guard bit above the shifted input keeps the rounding add from wrapping.
    localparam int unsigned EW  = fx_imax(InWidth + ShL + 1, OutWidth + 1);

    localparam logic signed [EW-1:0] MaxV = EW'(fx_max(OutWidth));
    localparam logic signed [EW-1:0] MinV = EW'(fx_min(OutWidth));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;

    assign ext = EW'(value);

    generate
        if (ShR > 0) begin : g_round
            assign shifted = (ext + (EW'(1) <<< (ShR - 1))) >>> ShR;
        end else begin : g_widen
            assign shifted = ext <<< ShL;
        end
    endgenerate

    always_comb begin
        overflow = 1'b0;
        result   = OutWidth'(shifted);
        if (shifted > MaxV) begin
            overflow = 1'b1;
            result   = OutWidth'(MaxV);
        end else if (shifted < MinV) begin
            overflow = 1'b1;
            result   = OutWidth'(MinV);
        end
    end

endmodule

// File: rtl/fixed_sub_pipe.sv
// Two-stage valid/ready pipelined signed fixed-point subtractor s = a - b.
module fixed_sub_pipe
    import fixed_pkg::*;
#(
    parameter int unsigned AWidth   = 16,
    parameter int unsigned APoint   = 12,
    parameter int unsigned BWidth   = 16,
    parameter int unsigned BPoint   = 8,
    parameter int unsigned OutWidth = 16,
    parameter int unsigned OutPoint = 13
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [AWidth-1:0]   a_i,
    input  logic [BWidth-1:0]   b_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [OutWidth-1:0] s_o,
    output logic                overflow_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int unsigned IP = fx_imax(APoint, BPoint);
    localparam int unsigned IW = fx_imax(fx_int_bits(AWidth, APoint),
                                         fx_int_bits(BWidth, BPoint)) + IP + 1;

    generate
        if (!fx_fmt_ok(AWidth, APoint) || !fx_fmt_ok(BWidth, BPoint) ||
            !fx_fmt_ok(OutWidth, OutPoint)) begin : g_bad_format
            $error("fixed_sub_pipe: widths must be >= 2 and 0 <= point < width");
        end
    endgenerate

    logic signed [IW-1:0]       a_al;
    logic signed [IW-1:0]       b_al;
    logic signed [IW-1:0]       d1;
    logic                       v1;
    logic signed [OutWidth-1:0] rs;
    logic                       rov;
    logic                       adv1;
    logic                       adv2;

    // Align both operands to the common internal binary point.
    assign a_al = IW'($signed(a_i)) <<< (IP - APoint);
    assign b_al = IW'($signed(b_i)) <<< (IP - BPoint);

    assign adv2    = !valid_o || ready_i;
    assign adv1    = !v1 || adv2;
    assign ready_o = adv1;

    fixed_resize #(
        .InWidth (IW),
        .InPoint (IP),
        .OutWidth(OutWidth),
        .OutPoint(OutPoint)
    ) u_resize (
        .value   (d1),
        .result  (rs),
        .overflow(rov)
    );

    // Stage 1: full-precision difference.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (adv1) begin
            v1 <= valid_i;
            if (valid_i) begin
                d1 <= a_al - b_al;
            end
        end
    end

    // Stage 2: registered resize result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o    <= 1'b0;
            s_o        <= '0;
            overflow_o <= 1'b0;
        end else if (adv2) begin
            valid_o <= v1;
            if (v1) begin
                s_o        <= rs;
                overflow_o <= rov;
            end
        end
    end

endmodule

// File: tb/tb_fixed_sub_pipe.sv
// Bench for fixed_sub_pipe: default format plus an OutPoint=10 variant sharing the stream.
module tb_fixed_sub_pipe;

    typedef struct {
        int s16;
        bit ov16;
        int s10;
        bit ov10;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int s16;
        bit ov16;
        int s10;
        bit ov10;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o, valid_o, overflow_o;
    logic [15:0] s_o;
    logic        ready10, valid10, ov10;
    logic [15:0] s10;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   prev_stall = 1'b0;
    logic [15:0] prev_s = '0;
    logic        prev_ov = 1'b0;

    always #5 clk_i = ~clk_i;

    fixed_sub_pipe dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
        .ready_o(ready_o), .s_o(s_o), .overflow_o(overflow_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    fixed_sub_pipe #(.OutPoint(10)) dut_p10 (
        .clk_i(clk_i), .rstn_i(rstn_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
        .ready_o(ready10), .s_o(s10), .overflow_o(ov10), .valid_o(valid10),
        .ready_i(ready_i)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Real-valued reference: exact in double for these formats.
    function automatic void model(input int a, input int b, input int point,
                                  output int s, output bit ov);
        real x;
        real y;
        x = real'(a) / 4096.0 - real'(b) / 256.0;
        y = $floor(x * (2.0 ** point) + 0.5);
        ov = 1'b0;
        if (y > 32767.0) begin
            s = 32767; ov = 1'b1;
        end else if (y < -32768.0) begin
            s = -32768; ov = 1'b1;
        end else begin
            s = $rtoi(y);
        end
    endfunction

    // One clock: drive at negedge, then evaluate handshakes for the coming edge.
    task automatic cycle(input bit v, input int a, input int b, input bit r,
                         input bit use_model, input exp_t hand, output bit accepted);
        exp_t e;
        exp_t got;
        @(negedge clk_i);
        valid_i = v;
        a_i     = 16'(a);
        b_i     = 16'(b);
        ready_i = r;
        #1;
        check("valid_p10_vs_main", longint'(valid10), longint'(valid_o));
        check("ready_p10_vs_main", longint'(ready10), longint'(ready_o));
        if (prev_stall) begin
            check("stall_valid_held", longint'(valid_o), 1);
            check("stall_s_held", longint'($signed(s_o)), longint'($signed(prev_s)));
            check("stall_ov_held", longint'(overflow_o), longint'(prev_ov));
        end
        accepted = valid_i && ready_o;
        if (accepted) begin
            if (use_model) begin
                model(a, b, 13, e.s16, e.ov16);
                model(a, b, 10, e.s10, e.ov10);
            end else begin
                e = hand;
            end
            q.push_back(e);
        end
        if (valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                got = q.pop_front();
                check("s_o", longint'($signed(s_o)), longint'(got.s16));
                check("overflow_o", longint'(overflow_o), longint'(got.ov16));
                check("s_o_p10", longint'($signed(s10)), longint'(got.s10));
                check("overflow_o_p10", longint'(ov10), longint'(got.ov10));
            end
        end
        prev_stall = valid_o && !ready_i;
        prev_s     = s_o;
        prev_ov    = overflow_o;
    endtask

    task automatic drain();
        bit   acc;
        exp_t none;
        none = '{0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 50 && (q.size() != 0 || valid_o); i++) begin
            cycle(1'b0, 0, 0, 1'b1, 1'b0, none, acc);
        end
        check("drain_queue_empty", longint'(q.size()), 0);
    endtask

    vec_t vecs[10];

    initial begin
        bit   acc;
        exp_t none;
        exp_t hand;
        int   a;
        int   b;
        none = '{0, 1'b0, 0, 1'b0};

        vecs[0] = '{6144, 512, -4096, 1'b0, -512, 1'b0};
        vecs[1] = '{-1024, -742, 21696, 1'b0, 2712, 1'b0};
        vecs[2] = '{28672, -512, 32767, 1'b1, 9216, 1'b0};
        vecs[3] = '{-28672, 512, -32768, 1'b1, -9216, 1'b0};
        vecs[4] = '{1, 0, 2, 1'b0, 0, 1'b0};
        vecs[5] = '{2, 0, 4, 1'b0, 1, 1'b0};
        vecs[6] = '{-2, 0, -4, 1'b0, 0, 1'b0};
        vecs[7] = '{-3, 0, -6, 1'b0, -1, 1'b0};
        vecs[8] = '{32767, -32768, 32767, 1'b1, 32767, 1'b1};
        vecs[9] = '{-32768, 32767, -32768, 1'b1, -32768, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_valid_o", longint'(valid_o), 0);
        check("reset_s_o", longint'(s_o), 0);
        check("reset_overflow_o", longint'(overflow_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        check("post_reset_ready_o", longint'(ready_o), 1);

        // Latency: one pair, result exactly two edges later.
        hand = '{vecs[0].s16, vecs[0].ov16, vecs[0].s10, vecs[0].ov10};
        cycle(1'b1, vecs[0].a, vecs[0].b, 1'b1, 1'b0, hand, acc);
        check("latency_accept", longint'(acc), 1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, none, acc);
        check("latency_not_early", longint'(valid_o), 0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, none, acc);
        check("latency_valid_at_2", longint'(q.size()), 0);
        drain();

        // Table vectors back-to-back at full rate.
        foreach (vecs[i]) begin
            hand = '{vecs[i].s16, vecs[i].ov16, vecs[i].s10, vecs[i].ov10};
            cycle(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0, hand, acc);
            check("full_rate_accept", longint'(acc), 1);
        end
        drain();

        // Backpressure: two accepted, third refused, then in-order drain.
        cycle(1'b1, 6144, 512, 1'b0, 1'b1, none, acc);
        check("bp_accept_1", longint'(acc), 1);
        cycle(1'b1, -1024, -742, 1'b0, 1'b1, none, acc);
        check("bp_accept_2", longint'(acc), 1);
        cycle(1'b1, 28672, -512, 1'b0, 1'b1, none, acc);
        check("bp_refuse_3", longint'(acc), 0);
        cycle(1'b1, 28672, -512, 1'b0, 1'b1, none, acc);
        check("bp_still_full", longint'(ready_o), 0);
        for (int i = 0; i < 10 && !acc; i++) begin
            cycle(1'b1, 28672, -512, 1'b1, 1'b1, none, acc);
        end
        check("bp_accept_3", longint'(acc), 1);
        drain();

        // Random stream with random handshakes and a mid-stream reset.
        for (int n = 0; n < 10000; ) begin
            if ($urandom_range(1, 0) == 1) begin
                a = int'($signed(16'($urandom)));
                b = int'($signed(16'($urandom)));
            end else begin
                a = $urandom_range(8000, 0) - 4000;
                b = $urandom_range(600, 0) - 300;
            end
            cycle($urandom_range(9, 0) < 7, a, b, $urandom_range(9, 0) < 7, 1'b1, none, acc);
            if (acc) n++;
            if (n == 5000 && acc) begin
                #2;
                rstn_i = 1'b0;
                #1;
                check("midreset_valid_o", longint'(valid_o), 0);
                check("midreset_valid_p10", longint'(valid10), 0);
                check("midreset_s_o", longint'(s_o), 0);
                check("midreset_overflow_o", longint'(overflow_o), 0);
                q.delete();
                prev_stall = 1'b0;
                valid_i = 1'b0;
                repeat (2) @(negedge clk_i);
                rstn_i = 1'b1;
                n++;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
